sync_hdr_aligner: RTL and testbench

//  Parametrised 64b/66b sync-header aligner for one Aurora lane. Sits after the gearbox buffer.

---
 rtl/sync_hdr_aligner_pkg.sv | 19 +
 rtl/sync_hdr_aligner_seeker.sv | 74 +++++++
 rtl/sync_hdr_aligner.sv | 179 +++++++++++++++++
 tb/tb_sync_hdr_aligner.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_hdr_aligner_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sync_hdr_pkg
// Description : Shared types and helpers for the 64b/66b sync-header aligner.
// Revision    : 1.0 - initial release
// ============================================================================
package sync_hdr_pkg;

    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} align_state_t;

    localparam logic [1:0] HDR_DATA = 2'b01;
    localparam logic [1:0] HDR_CTRL = 2'b10;

    function automatic logic hdr_valid(logic [1:0] h);
        return (h == HDR_DATA) || (h == HDR_CTRL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_hdr_aligner_seeker.sv
`default_nettype none
// ============================================================================
// Module      : sync_hdr_seeker
// Description : One round-robin offset seeker; counts consecutive valid
//               headers at its current offset and steps on a miss.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_hdr_seeker
    import sync_hdr_pkg::*;
#(
    parameter int START_POS = 0,
    parameter int STEP      = 4,
    parameter int MAX_POS   = 65,
    parameter int LOCK_CNT  = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [193:0] gbox_buffer,
    input  logic [5:0]   gbox_cnt,
    input  logic         buffer_dv,
    input  logic         freeze,
    input  logic         restart,
    output logic         hit,
    output logic [6:0]   pos
);

    localparam int CW = $clog2(LOCK_CNT + 1);
    localparam logic [7:0]    C_START = 8'(START_POS);
    localparam logic [7:0]    C_STEP  = 8'(STEP);
    localparam logic [7:0]    C_MAX   = 8'(MAX_POS);
    localparam logic [CW-1:0] C_HIT   = CW'(LOCK_CNT - 1);
    localparam logic [CW-1:0] C_SAT   = CW'(LOCK_CNT);

    logic [7:0]    pos_q, pos_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    hdr_idx;
    logic [7:0]    pos_step;
    logic          hdr_ok;

    assign hdr_idx  = {2'b00, gbox_cnt} + pos_q;
    assign hdr_ok   = hdr_valid(gbox_buffer[hdr_idx +: 2]);
    assign pos_step = pos_q + C_STEP;
    assign hit      = buffer_dv && !freeze && hdr_ok && (cnt_q == C_HIT);
    assign pos      = pos_q[6:0];

    // Restart outranks freeze so the lock/unlock edge can reseed a frozen seeker.
    always_comb begin
        pos_d = pos_q;
        cnt_d = cnt_q;
        if (restart) begin
            pos_d = C_START;
            cnt_d = '0;
        end else if (buffer_dv && !freeze) begin
            if (hdr_ok) begin
                if (cnt_q != C_SAT) cnt_d = cnt_q + CW'(1);
            end else begin
                cnt_d = '0;
                pos_d = (pos_step > C_MAX) ? C_START : pos_step;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pos_q <= C_START;
            cnt_q <= '0;
        end else begin
            pos_q <= pos_d;
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sync_hdr_aligner.sv
`default_nettype none
// ============================================================================
// Module      : sync_hdr_aligner
// Description : 64b/66b sync-header aligner with parallel seekers, lock FSM
//               and error hysteresis. Optional counters: SYNC_HDR_ALIGNER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_hdr_aligner
    import sync_hdr_pkg::*;
#(
    parameter int NUM_SEEKERS = 4,
    parameter int MAX_POS     = 65,
    parameter int LOCK_CNT    = 32,
    parameter int WINDOW_LEN  = 64,
    parameter int UNLOCK_ERR  = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [193:0] gbox_buffer,
    input  logic [5:0]   gbox_cnt,
    input  logic         buffer_dv,
    output logic         is_synced,
    output logic [6:0]   offset_pos,
    output logic         align_state,
    output logic         hdr_err
`ifdef SYNC_HDR_ALIGNER_STATS_EN
    ,
    output logic [15:0]  lock_loss_cnt,
    output logic [15:0]  hdr_err_cnt
`endif
);

    localparam int IW = (NUM_SEEKERS > 1) ? $clog2(NUM_SEEKERS) : 1;
    localparam int WW = $clog2(WINDOW_LEN + 1);
    localparam int EW = $clog2(UNLOCK_ERR + 1);
    localparam logic [WW-1:0] C_WIN_LAST = WW'(WINDOW_LEN - 1);
    localparam logic [EW-1:0] C_ERR_LAST = EW'(UNLOCK_ERR - 1);

    align_state_t           state_q, state_d;
    logic [6:0]             offset_pos_q, offset_pos_d;
    logic [IW-1:0]          prev_winner_q, prev_winner_d;
    logic [WW-1:0]          win_cnt_q, win_cnt_d;
    logic [EW-1:0]          err_cnt_q, err_cnt_d;
    logic                   hdr_err_q, hdr_err_d;
    logic [NUM_SEEKERS-1:0] seek_hit;
    logic [6:0]             seek_pos [NUM_SEEKERS];
    logic [IW-1:0]          win_idx;
    logic                   any_hit;
    logic                   seek_freeze, seek_restart, unlock_evt;
    logic [7:0]             lock_idx;
    logic                   lock_bad;

    assign seek_freeze = (state_q == LOCKED);

    generate
        for (genvar k = 0; k < NUM_SEEKERS; k++) begin : g_seeker
            sync_hdr_seeker #(
                .START_POS (k),
                .STEP      (NUM_SEEKERS),
                .MAX_POS   (MAX_POS),
                .LOCK_CNT  (LOCK_CNT)
            ) u_seeker (
                .clk_i       (clk_i),
                .rst_i       (rst_i),
                .gbox_buffer (gbox_buffer),
                .gbox_cnt    (gbox_cnt),
                .buffer_dv   (buffer_dv),
                .freeze      (seek_freeze),
                .restart     (seek_restart),
                .hit         (seek_hit[k]),
                .pos         (seek_pos[k])
            );
        end
    endgenerate

    // Sticky arbitration: the last winner keeps priority, else lowest index.
    always_comb begin
        any_hit = |seek_hit;
        win_idx = '0;
        for (int k = NUM_SEEKERS - 1; k >= 0; k--) begin
            if (seek_hit[k]) win_idx = IW'(k);
        end
        if (seek_hit[prev_winner_q]) win_idx = prev_winner_q;
    end

    assign lock_idx = {2'b00, gbox_cnt} + {1'b0, offset_pos_q};
    assign lock_bad = !hdr_valid(gbox_buffer[lock_idx +: 2]);

    always_comb begin
        state_d       = state_q;
        offset_pos_d  = offset_pos_q;
        prev_winner_d = prev_winner_q;
        win_cnt_d     = win_cnt_q;
        err_cnt_d     = err_cnt_q;
        hdr_err_d     = 1'b0;
        seek_restart  = 1'b0;
        unlock_evt    = 1'b0;
        if (buffer_dv) begin
            case (state_q)
                HUNT: begin
                    if (any_hit) begin
                        state_d       = LOCKED;
                        offset_pos_d  = seek_pos[win_idx];
                        prev_winner_d = win_idx;
                        seek_restart  = 1'b1;
                    end
                end
                LOCKED: begin
                    hdr_err_d = lock_bad;
                    // Threshold error outranks the window boundary.
                    if (lock_bad && (err_cnt_q == C_ERR_LAST)) begin
                        state_d      = HUNT;
                        win_cnt_d    = '0;
                        err_cnt_d    = '0;
                        seek_restart = 1'b1;
                        unlock_evt   = 1'b1;
                    end else if (win_cnt_q == C_WIN_LAST) begin
                        win_cnt_d = '0;
                        err_cnt_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + WW'(1);
                        err_cnt_d = err_cnt_q + EW'(lock_bad);
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= HUNT;
            offset_pos_q  <= '0;
            prev_winner_q <= '0;
            win_cnt_q     <= '0;
            err_cnt_q     <= '0;
            hdr_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            offset_pos_q  <= offset_pos_d;
            prev_winner_q <= prev_winner_d;
            win_cnt_q     <= win_cnt_d;
            err_cnt_q     <= err_cnt_d;
            hdr_err_q     <= hdr_err_d;
        end
    end

    assign is_synced   = (state_q == LOCKED);
    assign align_state = state_q;
    assign offset_pos  = offset_pos_q;
    assign hdr_err     = hdr_err_q;

`ifdef SYNC_HDR_ALIGNER_STATS_EN
    logic [15:0] lock_loss_cnt_q, lock_loss_cnt_d;
    logic [15:0] hdr_err_cnt_q, hdr_err_cnt_d;

    always_comb begin
        lock_loss_cnt_d = lock_loss_cnt_q;
        hdr_err_cnt_d   = hdr_err_cnt_q;
        if (unlock_evt && (lock_loss_cnt_q != 16'hFFFF)) lock_loss_cnt_d = lock_loss_cnt_q + 16'd1;
        if (hdr_err_d && (hdr_err_cnt_q != 16'hFFFF))    hdr_err_cnt_d   = hdr_err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_loss_cnt_q <= '0;
            hdr_err_cnt_q   <= '0;
        end else begin
            lock_loss_cnt_q <= lock_loss_cnt_d;
            hdr_err_cnt_q   <= hdr_err_cnt_d;
        end
    end

    assign lock_loss_cnt = lock_loss_cnt_q;
    assign hdr_err_cnt   = hdr_err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_hdr_aligner.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_hdr_aligner
// Description : Randomised self-checking bench with a behavioural reference
//               model; optional counters covered under SYNC_HDR_ALIGNER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_hdr_aligner;
    import sync_hdr_pkg::*;

    localparam int S          = 4;
    localparam int MAX_POS    = 65;
    localparam int LOCK_CNT   = 32;
    localparam int WINDOW_LEN = 64;
    localparam int UNLOCK_ERR = 16;

    // Relative header patterns (bit i sits at gbox_cnt + i)
    localparam logic [67:0] P_ZERO = 68'd0;
    localparam logic [67:0] P_37   = 68'd1 << 38;  // offset 37 = 2'b10, offset 38 = 2'b01
    localparam logic [67:0] P_45   = 68'd1 << 5;   // offset 4 = 2'b10, offset 5 = 2'b01
    localparam logic [67:0] P_5    = 68'd1 << 6;   // offset 5 = 2'b10, offset 6 = 2'b01

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic [193:0] gbox_buffer = '0;
    logic [5:0]   gbox_cnt = '0;
    logic         buffer_dv = 1'b0;
    logic         is_synced, align_state, hdr_err;
    logic [6:0]   offset_pos;
    logic         is_synced2, align_state2, hdr_err2;
    logic [6:0]   offset_pos2;
`ifdef SYNC_HDR_ALIGNER_STATS_EN
    logic [15:0]  lock_loss_cnt, hdr_err_cnt, lock_loss_cnt2, hdr_err_cnt2;
`endif

    always #5 clk_i = ~clk_i;

    sync_hdr_aligner #(.NUM_SEEKERS(S)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .gbox_buffer(gbox_buffer), .gbox_cnt(gbox_cnt),
        .buffer_dv(buffer_dv), .is_synced(is_synced), .offset_pos(offset_pos),
        .align_state(align_state), .hdr_err(hdr_err)
`ifdef SYNC_HDR_ALIGNER_STATS_EN
        , .lock_loss_cnt(lock_loss_cnt), .hdr_err_cnt(hdr_err_cnt)
`endif
    );

    sync_hdr_aligner #(.NUM_SEEKERS(2)) dut2 (
        .clk_i(clk_i), .rst_i(rst_i), .gbox_buffer(gbox_buffer), .gbox_cnt(gbox_cnt),
        .buffer_dv(buffer_dv), .is_synced(is_synced2), .offset_pos(offset_pos2),
        .align_state(align_state2), .hdr_err(hdr_err2)
`ifdef SYNC_HDR_ALIGNER_STATS_EN
        , .lock_loss_cnt(lock_loss_cnt2), .hdr_err_cnt(hdr_err_cnt2)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state for the S=4 instance
    int m_pos [S];
    int m_cnt [S];
    bit m_locked;
    int m_off, m_prev, m_win, m_err, m_ll, m_he;
    bit m_hdr_err;

    function automatic bit hv(input int p);
        logic [1:0] h;
        h = gbox_buffer[int'(gbox_cnt) + p +: 2];
        return (h == 2'b01) || (h == 2'b10);
    endfunction

    task automatic model_step();
        bit hit [S];
        bit v;
        int w, wpos;
        m_hdr_err = 1'b0;
        if (rst_i) begin
            m_locked = 0; m_off = 0; m_prev = 0; m_win = 0; m_err = 0; m_ll = 0; m_he = 0;
            for (int k = 0; k < S; k++) begin m_pos[k] = k; m_cnt[k] = 0; end
            return;
        end
        if (!buffer_dv) return;
        if (!m_locked) begin
            w = -1;
            for (int k = 0; k < S; k++) begin
                hit[k] = hv(m_pos[k]) && (m_cnt[k] == LOCK_CNT - 1);
                if (hit[k] && w < 0) w = k;
            end
            if (hit[m_prev]) w = m_prev;
            wpos = (w >= 0) ? m_pos[w] : 0;
            for (int k = 0; k < S; k++) begin
                v = hv(m_pos[k]);
                if (v) m_cnt[k] = (m_cnt[k] < LOCK_CNT) ? m_cnt[k] + 1 : LOCK_CNT;
                else begin
                    m_cnt[k] = 0;
                    m_pos[k] = (m_pos[k] + S > MAX_POS) ? k : m_pos[k] + S;
                end
            end
            if (w >= 0) begin
                m_locked = 1; m_off = wpos; m_prev = w;
                for (int k = 0; k < S; k++) m_cnt[k] = 0;
            end
        end else begin
            v = !hv(m_off);
            m_win++;
            if (v) begin
                m_err++; m_hdr_err = 1'b1;
                if (m_he < 65535) m_he++;
            end
            if (m_err >= UNLOCK_ERR) begin
                m_locked = 0; m_win = 0; m_err = 0;
                if (m_ll < 65535) m_ll++;
                for (int k = 0; k < S; k++) begin m_pos[k] = k; m_cnt[k] = 0; end
            end else if (m_win >= WINDOW_LEN) begin
                m_win = 0; m_err = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_step();
        #1;
        check_eq("is_synced", {31'd0, is_synced}, {31'd0, m_locked});
        check_eq("offset_pos", {25'd0, offset_pos}, m_off);
        check_eq("align_state", {31'd0, align_state}, {31'd0, m_locked});
        check_eq("hdr_err", {31'd0, hdr_err}, {31'd0, m_hdr_err});
    endtask

    // Random junk everywhere, pattern placed at a random window base
    task automatic set_in(input bit v, input logic [67:0] rel);
        logic [193:0] b;
        int base;
        for (int i = 0; i < 194; i++) b[i] = 1'($urandom_range(0, 1));
        base = $urandom_range(0, 63);
        for (int i = 0; i < 67; i++) b[base + i] = rel[i];
        gbox_buffer = b;
        gbox_cnt    = 6'(base);
        buffer_dv   = v;
    endtask

    task automatic run_pat(input logic [67:0] pat, input int n);
        for (int i = 0; i < n; i++) begin
            set_in(1'b1, pat);
            tick();
        end
    endtask

    // Returns dv beats consumed until lock is seen on the chosen instance, -1 on timeout
    task automatic run_until_lock(input logic [67:0] pat, input bit toggle, input bit use2,
                                  output int dvs);
        bit v;
        dvs = 0;
        for (int c = 0; c < 400; c++) begin
            v = toggle ? ((c % 2) == 0) : 1'b1;
            set_in(v, pat);
            tick();
            if (v) dvs++;
            if (use2 ? is_synced2 : is_synced) return;
        end
        dvs = -1;
    endtask

    initial begin
        int dvs, pulses, t, bad_pct;
        logic [67:0] rel;

        // Reset
        rst_i = 1'b1;
        set_in(1'b1, P_37);
        repeat (3) tick();
        check_eq("rst_synced", {31'd0, is_synced}, 0);
        check_eq("rst_offset", {25'd0, offset_pos}, 0);
        check_eq("rst_hdr_err", {31'd0, hdr_err}, 0);
        rst_i = 1'b0;

        // Single valid offset 37, continuous dv
        run_until_lock(P_37, 1'b0, 1'b0, dvs);
        check_eq("lock37_dvs", dvs, 41);
        check_eq("lock37_offset", {25'd0, offset_pos}, 37);

        // 15 bad headers in one window keep the lock
        pulses = 0;
        for (int i = 0; i < WINDOW_LEN; i++) begin
            set_in(1'b1, (i < 15) ? P_ZERO : P_37);
            tick();
            if (hdr_err) pulses++;
        end
        check_eq("win15_pulses", pulses, 15);
        check_eq("win15_locked", {31'd0, is_synced}, 1);

        // 16 bad headers drop the lock one cycle after the 16th
        for (int i = 0; i < UNLOCK_ERR; i++) begin
            set_in(1'b1, P_ZERO);
            tick();
            if (i == UNLOCK_ERR - 2) check_eq("err15_locked", {31'd0, is_synced}, 1);
        end
        check_eq("err16_unlock", {31'd0, is_synced}, 0);
        check_eq("err16_state", {31'd0, align_state}, 0);
        check_eq("err16_offset_held", {25'd0, offset_pos}, 37);

        // Relock, then reset mid-lock
        run_until_lock(P_37, 1'b0, 1'b0, dvs);
        check_eq("relock37_dvs", dvs, 41);
        rst_i = 1'b1;
        set_in(1'b1, P_37);
        tick();
        check_eq("midrst_synced", {31'd0, is_synced}, 0);
        check_eq("midrst_offset", {25'd0, offset_pos}, 0);
        check_eq("midrst_state", {31'd0, align_state}, 0);
        repeat (2) tick();
        rst_i = 1'b0;

        // dv toggling: lock still after 41 dv beats
        run_until_lock(P_37, 1'b1, 1'b0, dvs);
        check_eq("toggle_dvs", dvs, 41);
        check_eq("toggle_offset", {25'd0, offset_pos}, 37);

        // Two-seeker instance: simultaneous hits and sticky winner
        rst_i = 1'b1;
        set_in(1'b1, P_45);
        tick();
        rst_i = 1'b0;
        run_until_lock(P_45, 1'b0, 1'b1, dvs);
        check_eq("s2_first_dvs", dvs, 34);
        check_eq("s2_first_offset", {25'd0, offset_pos2}, 4);
        run_pat(P_5, UNLOCK_ERR);
        check_eq("s2_unlock1", {31'd0, is_synced2}, 0);
        run_until_lock(P_5, 1'b0, 1'b1, dvs);
        check_eq("s2_second_offset", {25'd0, offset_pos2}, 5);
        run_pat(P_ZERO, UNLOCK_ERR);
        check_eq("s2_unlock2", {31'd0, is_synced2}, 0);
        run_until_lock(P_45, 1'b0, 1'b1, dvs);
        check_eq("s2_sticky_dvs", dvs, 34);
        check_eq("s2_sticky_offset", {25'd0, offset_pos2}, 5);

        // Randomised segments against the model
        for (int seg = 0; seg < 12; seg++) begin
            t = $urandom_range(0, MAX_POS);
            bad_pct = (seg % 2 == 1) ? 40 : 3;
            for (int i = 0; i < 250; i++) begin
                for (int j = 0; j < 68; j++) rel[j] = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 99) >= bad_pct)
                    rel[t +: 2] = ($urandom_range(0, 1) == 1) ? HDR_DATA : HDR_CTRL;
                else
                    rel[t +: 2] = ($urandom_range(0, 1) == 1) ? 2'b00 : 2'b11;
                rst_i = ($urandom_range(0, 499) == 0);
                set_in($urandom_range(0, 3) != 0, rel);
                tick();
            end
        end
        rst_i = 1'b0;

`ifdef SYNC_HDR_ALIGNER_STATS_EN
        rst_i = 1'b1;
        set_in(1'b1, P_ZERO);
        tick();
        check_eq("stats_rst_ll", {16'd0, lock_loss_cnt}, 0);
        check_eq("stats_rst_he", {16'd0, hdr_err_cnt}, 0);
        rst_i = 1'b0;
        run_until_lock(P_37, 1'b0, 1'b0, dvs);
        run_pat(P_ZERO, 2);
        run_pat(P_37, WINDOW_LEN - 2);
        run_pat(P_ZERO, UNLOCK_ERR);
        for (int n = 0; n < 2; n++) begin
            run_until_lock(P_37, 1'b0, 1'b0, dvs);
            run_pat(P_ZERO, UNLOCK_ERR);
        end
        check_eq("stats_lock_loss", {16'd0, lock_loss_cnt}, 3);
        check_eq("stats_hdr_err", {16'd0, hdr_err_cnt}, 50);
        check_eq("stats_ll_model", {16'd0, lock_loss_cnt}, m_ll);
        check_eq("stats_he_model", {16'd0, hdr_err_cnt}, m_he);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire
